// File: rtl/keycode_tx.sv
// keycode_tx: emits one press/release scan-code event pair for a BCD digit.
// A digit is translated to a top-row or keypad scan code, the key is shown as
// pressed for HOLD_CYC cycles (or less if aborted), released, and followed by
// GAP_CYC idle cycles before a one-cycle done pulse in the first IDLE cycle.
module keycode_tx #(
   parameter int HOLD_CYC = 10,
   parameter int GAP_CYC  = 5
) (
   input  logic         clk_100Hz,
   input  logic         rst_n,
   input  logic         send,
   input  logic [3:0]   digit,
   input  logic         pad_sel,
   input  logic         abort,
   output logic [8:0]   last_change,
   output logic [511:0] key_down,
   output logic         key_valid,
   output logic         busy,
   output logic         done,
   output logic         err
);

   // One shared counter serves both the hold and the gap phases.
   localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRESS   = 3'd1,
      ST_HOLD    = 3'd2,
      ST_RELEASE = 3'd3,
      ST_GAP     = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [8:0]       last_change_q, last_change_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [8:0]       lut_code;
   logic             digit_ok;
   logic             key_held;

   // Digit to scan-code translation for both code sets; flags digits above 9.
   always_comb begin
      lut_code = 9'h000;
      digit_ok = 1'b1;
      case (digit)
         4'd0:    lut_code = pad_sel ? 9'h070 : 9'h045;
         4'd1:    lut_code = pad_sel ? 9'h069 : 9'h016;
         4'd2:    lut_code = pad_sel ? 9'h072 : 9'h01E;
         4'd3:    lut_code = pad_sel ? 9'h07A : 9'h026;
         4'd4:    lut_code = pad_sel ? 9'h06B : 9'h025;
         4'd5:    lut_code = pad_sel ? 9'h073 : 9'h02E;
         4'd6:    lut_code = pad_sel ? 9'h074 : 9'h036;
         4'd7:    lut_code = pad_sel ? 9'h06C : 9'h03D;
         4'd8:    lut_code = pad_sel ? 9'h075 : 9'h03E;
         4'd9:    lut_code = pad_sel ? 9'h07D : 9'h046;
         default: digit_ok = 1'b0;
      endcase
   end

   // State, counter and output registers; reset drops everything at once.
   always_ff @(posedge clk_100Hz or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         last_change_q <= 9'h000;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_change_q <= last_change_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   // Next-state logic. The code is latched into last_change on acceptance, so
   // it is already valid in the PRESS cycle and is immune to later input changes.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      last_change_d = last_change_q;
      done_d        = 1'b0;
      err_d         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (send) begin
               if (digit_ok) begin
                  last_change_d = lut_code;
                  state_d       = ST_PRESS;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_PRESS: begin
            cnt_d   = '0;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (abort || (cnt_q == HOLD_LAST)) begin
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            cnt_d   = '0;
            state_d = ST_GAP;
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      key_valid = (state_q == ST_PRESS) || (state_q == ST_RELEASE);
      busy      = (state_q != ST_IDLE);
      key_held  = (state_q == ST_PRESS) || (state_q == ST_HOLD);
   end

   assign last_change = last_change_q;
   assign done        = done_q;
   assign err         = err_q;

   // One decoder per scan code keeps key_down one-hot (or all zero).
   generate
      for (genvar gi = 0; gi < 512; gi++) begin : g_key_down
         assign key_down[gi] = key_held && (last_change_q == 9'(gi));
      end
   endgenerate

endmodule

// File: tb/tb_keycode_tx.sv
// Self-checking bench for keycode_tx: directed scenarios plus randomized
// transfers, checked cycle by cycle against a timeline model.
module tb_keycode_tx;

   localparam int HOLD = 10;
   localparam int GAP  = 5;

   logic         clk_100Hz = 1'b0;
   logic         rst_n     = 1'b0;
   logic         send      = 1'b0;
   logic [3:0]   digit     = 4'd0;
   logic         pad_sel   = 1'b0;
   logic         abort     = 1'b0;
   logic [8:0]   last_change;
   logic [511:0] key_down;
   logic         key_valid, busy, done, err;

   int checks = 0;
   int errors = 0;

   logic [8:0] top_tbl [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                                9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};
   logic [8:0] pad_tbl [10] = '{9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
                                9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D};

   keycode_tx #(.HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
      .clk_100Hz   (clk_100Hz),
      .rst_n       (rst_n),
      .send        (send),
      .digit       (digit),
      .pad_sel     (pad_sel),
      .abort       (abort),
      .last_change (last_change),
      .key_down    (key_down),
      .key_valid   (key_valid),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk_100Hz = ~clk_100Hz;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] ref_code(input int d, input bit p);
      return p ? pad_tbl[d] : top_tbl[d];
   endfunction

   function automatic logic [511:0] onehot(input logic [8:0] c);
      logic [511:0] v;
      v = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk_100Hz);
      #1;
   endtask

   // Idle cycles: nothing should happen.
   task automatic idle(input int n, input string tag);
      send  = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         chk({tag, "_busy"}, busy, 0);
         chk({tag, "_kv"}, key_valid, 0);
         chk({tag, "_done"}, done, 0);
         chk({tag, "_kd"}, key_down, '0);
      end
   endtask

   // One transfer, from the send sample through the done cycle. abort_k < 0
   // means no abort, otherwise abort is raised in hold cycle abort_k (0-based).
   // With noise set, ignored send/abort pulses and digit changes are injected.
   task automatic xfer(input int d, input bit p, input int abort_k, input bit noise);
      logic [8:0] code;
      int h, total;
      code  = ref_code(d, p);
      h     = (abort_k < 0) ? HOLD : abort_k + 1;
      total = 2 + h + GAP;
      send    = 1'b1;
      digit   = 4'(d);
      pad_sel = p;
      abort   = 1'b0;
      for (int c = 0; c <= total; c++) begin
         tick();
         chk("kv", key_valid, (c == 0) || (c == h + 1));
         chk("busy", busy, c < total);
         chk("done", done, c == total);
         chk("err", err, 0);
         chk("last_change", last_change, code);
         chk("key_down", key_down, (c <= h) ? onehot(code) : '0);
         if (c == total) begin
            send  = 1'b0;
            abort = 1'b0;
         end else if (noise) begin
            send    = 1'($urandom_range(0, 1));
            digit   = 4'($urandom_range(0, 15));
            pad_sel = 1'($urandom_range(0, 1));
            if (c >= 1 && c <= h) abort = (c == abort_k + 1);
            else                  abort = 1'($urandom_range(0, 1));
         end else begin
            send  = 1'b0;
            abort = (abort_k >= 0) && (c == abort_k + 1);
         end
      end
   endtask

   initial begin
      // Reset state while rst_n is held low.
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_kv", key_valid, 0);
      chk("rst_lc", last_change, 0);
      chk("rst_kd", key_down, '0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      tick();
      #2 rst_n = 1'b1;
      idle(2, "post_rst");

      // Digit 3 on top row: 026, full hold, 17 busy cycles.
      xfer(3, 1'b0, -1, 1'b0);
      idle(2, "after_d3");

      // Digit 9 on keypad: 07D.
      xfer(9, 1'b1, -1, 1'b0);
      idle(1, "after_d9");

      // Invalid digit 12: one err pulse, no event.
      send  = 1'b1;
      digit = 4'd12;
      tick();
      send = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_kv", key_valid, 0);
      chk("err_busy", busy, 0);
      chk("err_kd", key_down, '0);
      tick();
      chk("err_clear", err, 0);
      chk("err_kv2", key_valid, 0);
      chk("err_busy2", busy, 0);
      chk("err_kd2", key_down, '0);
      idle(1, "after_err");

      // Abort in the 3rd hold cycle.
      xfer(7, 1'b0, 2, 1'b0);
      idle(1, "after_abort");

      // Ignored send/abort noise during the transfer, then back-to-back send
      // in the done cycle.
      xfer(1, 1'b1, -1, 1'b1);
      xfer(0, 1'b0, -1, 1'b0);
      idle(1, "after_b2b");

      // Reset in the middle of HOLD with digit 5.
      send    = 1'b1;
      digit   = 4'd5;
      pad_sel = 1'b0;
      tick();
      send = 1'b0;
      tick();
      tick();
      chk("pre_rst_kd", key_down, onehot(9'h02E));
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_kd", key_down, '0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_lc", last_change, 0);
      chk("mid_rst_kv", key_valid, 0);
      tick();
      #2 rst_n = 1'b1;
      idle(HOLD + GAP + 3, "no_release");
      xfer(5, 1'b0, -1, 1'b0);
      idle(1, "after_rst_xfer");

      // Randomized transfers, some aborted, some back-to-back.
      for (int n = 0; n < 8; n++) begin
         int d, ak;
         bit p;
         d  = $urandom_range(0, 9);
         p  = 1'($urandom_range(0, 1));
         ak = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, HOLD - 1));
         xfer(d, p, ak, 1'b1);
         if ($urandom_range(0, 2) == 0) begin
            d = $urandom_range(10, 15);
            send  = 1'b1;
            digit = 4'(d);
            tick();
            send = 1'b0;
            chk("rnd_err", err, 1);
            chk("rnd_err_busy", busy, 0);
            chk("rnd_err_kv", key_valid, 0);
         end else if ($urandom_range(0, 1) == 0) begin
            idle($urandom_range(1, 3), "rnd_idle");
         end
      end
      idle(2, "final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
